// File: rtl/elevator_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// elevator_scan_ctrl_if
// Purpose : Bundles the panel-side request inputs and the car status outputs
//           of the SCAN elevator controller into one interface.
// Signals : buttons       - per-floor request pulses/levels (panel -> ctrl)
//           door_hold     - keep door open while high      (panel -> ctrl)
//           current_floor - floor the car is at or last passed
//           door_open     - door open
//           moving        - car travelling between floors
//           direction     - 1 = up, 0 = down
//           reqs          - pending (unserved) requests
//           idle          - controller idle with nothing pending
// Modports: master = panel / display side, slave = controller.
// ---------------------------------------------------------------------------
interface elevator_scan_ctrl_if #(
  parameter int NUM_FLOORS = 5
);
  localparam int FLOOR_W = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;

  logic [NUM_FLOORS-1:0] buttons;
  logic                  door_hold;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  door_open;
  logic                  moving;
  logic                  direction;
  logic [NUM_FLOORS-1:0] reqs;
  logic                  idle;

  modport master (
    output buttons, door_hold,
    input  current_floor, door_open, moving, direction, reqs, idle
  );

  modport slave (
    input  buttons, door_hold,
    output current_floor, door_open, moving, direction, reqs, idle
  );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// ---------------------------------------------------------------------------
// elevator_scan_ctrl
// Purpose : Single-car elevator controller serving latched floor requests in
//           SCAN (collective) order. Travel time per hop and door dwell are
//           modelled with down-counters; door_hold or a re-press of the
//           current floor restarts the dwell.
// Ports   : clk   - system clock, rising edge
//           reset - synchronous, active-high
//           bus   - elevator_scan_ctrl_if.slave (requests in, status out)
// All outputs are driven straight from registers.
// ---------------------------------------------------------------------------
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS    = 5,
  parameter int DOOR_CYCLES   = 3,
  parameter int TRAVEL_CYCLES = 2
) (
  input logic                    clk,
  input logic                    reset,
  elevator_scan_ctrl_if.slave    bus
);

  localparam int FLOOR_W = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  localparam int MAX_CYC = (DOOR_CYCLES > TRAVEL_CYCLES) ? DOOR_CYCLES : TRAVEL_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;

  localparam logic [CNT_W-1:0] DWELL_RELOAD  = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRAVEL_RELOAD = CNT_W'(TRAVEL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVING    = 2'd1,
    S_DOOR_OPEN = 2'd2
  } state_t;

  state_t                r_state;
  logic [FLOOR_W-1:0]    r_floor;
  logic                  r_dir;
  logic                  r_door;
  logic                  r_moving;
  logic                  r_idle;
  logic [NUM_FLOORS-1:0] r_reqs;
  logic [CNT_W-1:0]      r_dwell;
  logic [CNT_W-1:0]      r_travel;

  // Per-floor position masks relative to the car, built without variable
  // part-selects so they stay legal at the top and bottom floors.
  logic [NUM_FLOORS-1:0] w_here;
  logic [NUM_FLOORS-1:0] w_above_mask;
  logic [NUM_FLOORS-1:0] w_below_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_pos
      assign w_here[gi]       = (r_floor == FLOOR_W'(gi));
      assign w_above_mask[gi] = (FLOOR_W'(gi) > r_floor);
      assign w_below_mask[gi] = (FLOOR_W'(gi) < r_floor);
    end
  endgenerate

  logic                  w_at_floor;
  logic                  w_btn_here;
  logic                  w_above;
  logic                  w_below;
  logic                  w_opening;
  logic [NUM_FLOORS-1:0] w_clear_mask;
  logic [NUM_FLOORS-1:0] w_reqs_next;
  logic                  w_reqs_next_empty;

  assign w_at_floor = |(r_reqs & w_here);
  assign w_btn_here = |(bus.buttons & w_here);
  assign w_above    = |(r_reqs & w_above_mask);
  assign w_below    = |(r_reqs & w_below_mask);

  // The current floor's request is dropped on the opening edge and on every
  // door-open edge, so re-presses while the door is open never stick.
  assign w_opening         = (r_state == S_IDLE) && w_at_floor;
  assign w_clear_mask      = (w_opening || (r_state == S_DOOR_OPEN)) ? w_here : '0;
  assign w_reqs_next       = (r_reqs | bus.buttons) & ~w_clear_mask;
  assign w_reqs_next_empty = (w_reqs_next == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_floor  <= '0;
      r_dir    <= 1'b1;
      r_door   <= 1'b0;
      r_moving <= 1'b0;
      r_idle   <= 1'b1;
      r_reqs   <= '0;
      r_dwell  <= '0;
      r_travel <= '0;
    end else begin
      r_reqs <= w_reqs_next;
      r_idle <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_at_floor) begin
            r_state <= S_DOOR_OPEN;
            r_door  <= 1'b1;
            r_dwell <= DWELL_RELOAD;
          end else if (r_dir ? w_above : w_below) begin
            // keep sweeping in the current direction
            r_state  <= S_MOVING;
            r_moving <= 1'b1;
            r_travel <= TRAVEL_RELOAD;
          end else if (r_dir ? w_below : w_above) begin
            // nothing left ahead: reverse the sweep
            r_dir    <= ~r_dir;
            r_state  <= S_MOVING;
            r_moving <= 1'b1;
            r_travel <= TRAVEL_RELOAD;
          end else begin
            r_idle <= w_reqs_next_empty;
          end
        end

        S_MOVING: begin
          if (r_travel == '0) begin
            r_floor  <= r_dir ? (r_floor + FLOOR_W'(1)) : (r_floor - FLOOR_W'(1));
            r_moving <= 1'b0;
            r_state  <= S_IDLE;
            r_idle   <= w_reqs_next_empty;
          end else begin
            r_travel <= r_travel - CNT_W'(1);
          end
        end

        S_DOOR_OPEN: begin
          if (bus.door_hold || w_btn_here) begin
            r_dwell <= DWELL_RELOAD;
          end else if (r_dwell == '0) begin
            r_door  <= 1'b0;
            r_state <= S_IDLE;
            r_idle  <= w_reqs_next_empty;
          end else begin
            r_dwell <= r_dwell - CNT_W'(1);
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_door   <= 1'b0;
          r_moving <= 1'b0;
        end
      endcase
    end
  end

  assign bus.current_floor = r_floor;
  assign bus.door_open     = r_door;
  assign bus.moving        = r_moving;
  assign bus.direction     = r_dir;
  assign bus.reqs          = r_reqs;
  assign bus.idle          = r_idle;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_elevator_scan_ctrl
// Purpose : Self-checking bench for elevator_scan_ctrl. A few directed
//           sequences followed by randomized buttons / door_hold / reset,
//           each cycle compared against a countdown-based behavioural model.
// ---------------------------------------------------------------------------
module tb_elevator_scan_ctrl;
  localparam int NF = 5;
  localparam int DC = 3;
  localparam int TC = 2;
  localparam int FW = $clog2(NF);

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  elevator_scan_ctrl_if #(.NUM_FLOORS(NF)) bus ();

  elevator_scan_ctrl #(
    .NUM_FLOORS   (NF),
    .DOOR_CYCLES  (DC),
    .TRAVEL_CYCLES(TC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: car position, sweep direction, pending set and two
  // "cycles remaining" timers for the door and the current hop.
  int m_floor;
  bit m_up;
  bit m_pend[NF];
  int m_door_left;
  int m_hop_left;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_floor     = 0;
    m_up        = 1'b1;
    m_door_left = 0;
    m_hop_left  = 0;
    for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
  endtask

  task automatic model_step(input logic [NF-1:0] btn, input logic hold, input logic rst);
    bit old[NF];
    bit door_was_open;
    bit opening;
    int f0;
    int n_above;
    int n_below;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NF; i++) old[i] = m_pend[i];
    f0            = m_floor;
    door_was_open = (m_door_left > 0);
    opening       = 1'b0;
    if (door_was_open) begin
      if (hold || btn[f0]) m_door_left = DC;
      else m_door_left = m_door_left - 1;
    end else if (m_hop_left > 0) begin
      m_hop_left = m_hop_left - 1;
      if (m_hop_left == 0) m_floor = m_up ? m_floor + 1 : m_floor - 1;
    end else if (old[f0]) begin
      opening     = 1'b1;
      m_door_left = DC;
    end else begin
      n_above = 0;
      n_below = 0;
      for (int i = 0; i < NF; i++) begin
        if (old[i] && i > f0) n_above++;
        if (old[i] && i < f0) n_below++;
      end
      if (m_up) begin
        if (n_above > 0) m_hop_left = TC;
        else if (n_below > 0) begin m_up = 1'b0; m_hop_left = TC; end
      end else begin
        if (n_below > 0) m_hop_left = TC;
        else if (n_above > 0) begin m_up = 1'b1; m_hop_left = TC; end
      end
    end
    for (int i = 0; i < NF; i++) begin
      m_pend[i] = old[i] | btn[i];
      if ((door_was_open || opening) && i == f0) m_pend[i] = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic [NF-1:0] exp_reqs;
    bit any;
    any = 1'b0;
    for (int i = 0; i < NF; i++) begin
      exp_reqs[i] = m_pend[i];
      any = any | m_pend[i];
    end
    check_val("current_floor", 32'(bus.current_floor), 32'(m_floor));
    check_val("door_open", 32'(bus.door_open), 32'(m_door_left > 0));
    check_val("moving", 32'(bus.moving), 32'(m_hop_left > 0));
    check_val("direction", 32'(bus.direction), 32'(m_up));
    check_val("reqs", 32'(bus.reqs), 32'(exp_reqs));
    check_val("idle", 32'(bus.idle), 32'(m_door_left == 0 && m_hop_left == 0 && !any));
    check_val("door_and_moving", 32'(bus.door_open & bus.moving), 32'd0);
  endtask

  task automatic drive(input logic [NF-1:0] btn, input logic hold, input logic rst);
    bus.buttons   = btn;
    bus.door_hold = hold;
    reset         = rst;
    @(posedge clk);
    model_step(btn, hold, rst);
    cyc++;
    #1;
    compare_all();
  endtask

  initial begin
    int hold_cnt;
    logic [NF-1:0] rb;
    logic rh;
    logic rr;
    bus.buttons   = '0;
    bus.door_hold = 1'b0;
    model_reset();

    // reset, then quiet idle
    repeat (2) drive('0, 1'b0, 1'b1);
    repeat (10) drive('0, 1'b0, 1'b0);
    // request at the current floor
    drive(5'b00001, 1'b0, 1'b0);
    repeat (8) drive('0, 1'b0, 1'b0);
    // travel to floor 3
    drive(5'b01000, 1'b0, 1'b0);
    repeat (16) drive('0, 1'b0, 1'b0);
    // door hold at floor 3 then release
    drive(5'b01000, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0);
    repeat (5) drive('0, 1'b1, 1'b0);
    repeat (5) drive('0, 1'b0, 1'b0);
    // request behind and ahead at once, then reset while moving
    drive(5'b10010, 1'b0, 1'b0);
    repeat (3) drive('0, 1'b0, 1'b0);
    drive(5'b00100, 1'b0, 1'b1);
    repeat (2) drive('0, 1'b0, 1'b0);

    hold_cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NF; i++) rb[i] = ($urandom_range(0, 15) == 0);
      if (hold_cnt == 0 && $urandom_range(0, 30) == 0) hold_cnt = $urandom_range(1, 6);
      rh = (hold_cnt > 0);
      if (hold_cnt > 0) hold_cnt--;
      rr = ($urandom_range(0, 299) == 0);
      drive(rb, rh, rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
